gpu_rect_loader: RTL and testbench
==================================

GPU_RECT_LOADER -- requirements
Module: gpu_rect_loader

Interface
REQ-001 SHALL have parameter COORD_WIDTH, default 16, width of coordinates and sizes.
REQ-002 SHALL have parameter RECT_COUNT, default 64, number of rectangles per frame.
REQ-003 SHALL have parameter START_DELAY, default 2, cycles from copy_start to the first stream word on data_in.
REQ-004 SHALL have parameter BG_COLOR, default 16'h0000, color returned when no rectangle covers a pixel.
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port copy_start  input  1  frame copy start pulse, shared with the DMA copy controller.
REQ-008 SHALL have port data_in  input  16  packet stream from the DMA copy controller.
REQ-009 SHALL have port query_valid  input  1  pixel query request.
REQ-010 SHALL have port pixel_x  input  COORD_WIDTH  query column, unsigned.
REQ-011 SHALL have port pixel_y  input  COORD_WIDTH  query row, unsigned.
REQ-012 SHALL have port pixel_valid  output  1  pixel_color is valid this cycle.
REQ-013 SHALL have port pixel_color  output  16  resolved pixel color.
REQ-014 SHALL have port frame_ready  output  1  rectangle table is complete and in use.
REQ-015 SHALL have port loading  output  1  a load is in progress.

Function
REQ-016 SHALL implement states IDLE, DELAY, LOAD and READY.
- IDLE: entered after reset.
- DELAY: counts START_DELAY cycles.
- LOAD: consumes 6*RECT_COUNT consecutive words.
- READY: table complete.
REQ-017 SHALL treat stream word k (k = 0 .. 6*RECT_COUNT-1) as valid on data_in exactly at cycle C+START_DELAY+k, where C is the cycle in which copy_start is sampled high in IDLE or READY.
- No valid or stall signal exists.
- The stream is strictly contiguous.
REQ-018 SHALL decode each 6-word packet, in order, as marker, x, y, width, height, color.
- The marker is ignored.
- x, y, width and height are truncated to COORD_WIDTH.
- color is the full 16 bits.
REQ-019 SHALL write packet n into table entry n, n = 0 .. RECT_COUNT-1, using a word counter (0..5) and a rect counter (0..RECT_COUNT-1).
REQ-020 SHALL move LOAD -> READY on the cycle after the last word (color of entry RECT_COUNT-1) is captured, and SHALL assert frame_ready while in READY.
REQ-021 SHALL ignore copy_start while in DELAY or LOAD.
REQ-022 SHALL leave READY for DELAY when copy_start is high in READY.
- frame_ready deasserts on the next cycle.
- Table entries are overwritten progressively, not cleared.
REQ-023 SHALL assert loading in DELAY and LOAD only.
REQ-024 SHALL register pixel_valid as query_valid delayed by exactly 1 cycle, independent of state.
REQ-025 SHALL treat entry i as covering a pixel iff all of the following hold:
- pixel_x >= x_i and pixel_x < x_i + w_i;
- pixel_y >= y_i and pixel_y < y_i + h_i;
- sums are evaluated at COORD_WIDTH+1 bits, so there is no wrap-around.
REQ-026 SHALL treat an entry with width 0 or height 0 as covering no pixel.
REQ-027 SHALL output, one cycle after query_valid, the color of the highest-index covering entry, or BG_COLOR if no entry covers the pixel.
REQ-028 SHALL output BG_COLOR for queries sampled while the state is not READY.
REQ-029 SHALL hold pixel_color at its last value while pixel_valid is 0.

Reset
REQ-030 SHALL, on reset high at any clock edge, including mid-LOAD:
- go to IDLE;
- clear all counters;
- set every table field to 0;
- drive pixel_valid=0, pixel_color=16'h0000, frame_ready=0, loading=0.
REQ-031 SHALL take reset priority over copy_start and query_valid in the same cycle.

Verification
REQ-032 Full load: copy_start, then 64 packets with entry 0 = (0,10,20,5,5,16'hF800) and all other entries of size 0 -> loading high for 2+384 cycles, then frame_ready=1; query (12,22) -> pixel_color 16'hF800 one cycle later; query (15,22) -> BG_COLOR.
REQ-033 Priority: entry 3 = (0,0,100,100,16'h001F) and entry 40 = (50,50,10,10,16'h07E0); query (55,55) -> 16'h07E0; query (49,55) -> 16'h001F.
REQ-034 Boundary: entry = (0,0xFFF0,0,0x0020,1,c), i.e. x=0xFFF0, w=0x20; query x=0xFFFF,y=0 -> c; query x=0x0005,y=0 -> BG_COLOR (no wrap).
REQ-035 Reload and ignore: copy_start pulsed again mid-LOAD -> no restart, frame_ready after the original 386 cycles; then copy_start in READY -> frame_ready=0 next cycle, and queries return BG_COLOR until the new load completes.
REQ-036 Reset mid-LOAD: reset at word 200 -> all outputs 0 next cycle, state IDLE; query after release -> BG_COLOR with pixel_valid=1, frame_ready=0.

Source files
------------

// File: rtl/gpu_rect_loader.sv
// Loads a table of RECT_COUNT rectangles from a fixed-latency DMA word stream and
// resolves pixel queries to the colour of the highest-index covering rectangle.
module gpu_rect_loader #(
   parameter int          COORD_WIDTH = 16,
   parameter int          RECT_COUNT  = 64,
   parameter int          START_DELAY = 2,
   parameter logic [15:0] BG_COLOR    = 16'h0000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   copy_start,
   input  logic [15:0]            data_in,
   input  logic                   query_valid,
   input  logic [COORD_WIDTH-1:0] pixel_x,
   input  logic [COORD_WIDTH-1:0] pixel_y,
   output logic                   pixel_valid,
   output logic [15:0]            pixel_color,
   output logic                   frame_ready,
   output logic                   loading
);

   localparam int RW = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1;
   localparam int DW = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;

   typedef enum logic [1:0] {IDLE, DELAY, LOAD, READY} state_t;

   state_t                          state_q;
   logic [DW-1:0]                   delay_q;
   logic [2:0]                      word_q;
   logic [RW-1:0]                   rect_q;
   logic                            frame_ready_q;
   logic                            loading_q;
   logic                            pixel_valid_q;
   logic [15:0]                     pixel_color_q;
   logic [15:0]                     hit_color_d;
   logic [RECT_COUNT-1:0]           hit;
   logic [RECT_COUNT-1:0][15:0]     entry_color;

   // Word k arrives START_DELAY cycles after copy_start, so DELAY lasts one cycle
   // less than START_DELAY and LOAD captures word 0 on its first cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         delay_q       <= '0;
         word_q        <= '0;
         rect_q        <= '0;
         frame_ready_q <= 1'b0;
         loading_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE, READY: begin
               if (copy_start) begin
                  delay_q       <= '0;
                  word_q        <= '0;
                  rect_q        <= '0;
                  frame_ready_q <= 1'b0;
                  loading_q     <= 1'b1;
                  state_q       <= (START_DELAY <= 1) ? LOAD : DELAY;
               end
            end
            DELAY: begin
               if (delay_q == DW'(START_DELAY - 2)) begin
                  state_q <= LOAD;
               end else begin
                  delay_q <= delay_q + 1'b1;
               end
            end
            LOAD: begin
               if (word_q == 3'd5) begin
                  word_q <= '0;
                  if (rect_q == RW'(RECT_COUNT - 1)) begin
                     rect_q        <= '0;
                     state_q       <= READY;
                     frame_ready_q <= 1'b1;
                     loading_q     <= 1'b0;
                  end else begin
                     rect_q <= rect_q + 1'b1;
                  end
               end else begin
                  word_q <= word_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   for (genvar gi = 0; gi < RECT_COUNT; gi++) begin : g_entry
      logic [COORD_WIDTH-1:0] x_q, y_q, w_q, h_q;
      logic [15:0]            color_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
         end else if (state_q == LOAD && rect_q == RW'(gi)) begin
            case (word_q)
               3'd1:    x_q     <= COORD_WIDTH'(data_in);
               3'd2:    y_q     <= COORD_WIDTH'(data_in);
               3'd3:    w_q     <= COORD_WIDTH'(data_in);
               3'd4:    h_q     <= COORD_WIDTH'(data_in);
               3'd5:    color_q <= data_in;
               default: ;
            endcase
         end
      end

      // One extra bit on the end coordinate keeps x+w from wrapping past zero.
      assign hit[gi] = ({1'b0, pixel_x} >= {1'b0, x_q}) &&
                       ({1'b0, pixel_x} <  ({1'b0, x_q} + {1'b0, w_q})) &&
                       ({1'b0, pixel_y} >= {1'b0, y_q}) &&
                       ({1'b0, pixel_y} <  ({1'b0, y_q} + {1'b0, h_q}));
      assign entry_color[gi] = color_q;
   end

   always_comb begin
      hit_color_d = BG_COLOR;
      for (int i = 0; i < RECT_COUNT; i++) begin
         if (hit[i]) begin
            hit_color_d = entry_color[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pixel_valid_q <= 1'b0;
         pixel_color_q <= 16'h0000;
      end else begin
         pixel_valid_q <= query_valid;
         if (query_valid) begin
            pixel_color_q <= (state_q == READY) ? hit_color_d : BG_COLOR;
         end
      end
   end

   assign pixel_valid = pixel_valid_q;
   assign pixel_color = pixel_color_q;
   assign frame_ready = frame_ready_q;
   assign loading     = loading_q;

endmodule

// File: tb/tb_gpu_rect_loader.sv
// Self-checking bench for gpu_rect_loader: directed frames with a query table,
// randomised frames checked against a rectangle-list model, and reset/reload cases.
module tb_gpu_rect_loader;

   localparam int          CW = 16;
   localparam int          RC = 64;
   localparam int          SD = 2;
   localparam logic [15:0] BG = 16'h0841;

   logic          clk;
   logic          reset;
   logic          copy_start;
   logic [15:0]   data_in;
   logic          query_valid;
   logic [CW-1:0] pixel_x;
   logic [CW-1:0] pixel_y;
   logic          pixel_valid;
   logic [15:0]   pixel_color;
   logic          frame_ready;
   logic          loading;

   int checks   = 0;
   int failures = 0;

   int          m_x [RC];
   int          m_y [RC];
   int          m_w [RC];
   int          m_h [RC];
   logic [15:0] m_c [RC];

   typedef struct {
      int          frame;
      int          px;
      int          py;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs [17];

   gpu_rect_loader #(
      .COORD_WIDTH(CW),
      .RECT_COUNT (RC),
      .START_DELAY(SD),
      .BG_COLOR   (BG)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .copy_start (copy_start),
      .data_in    (data_in),
      .query_valid(query_valid),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .pixel_valid(pixel_valid),
      .pixel_color(pixel_color),
      .frame_ready(frame_ready),
      .loading    (loading)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: scan from the top index down, first rectangle containing the point wins.
   function automatic logic [15:0] ref_color(input int px, input int py);
      for (int n = RC - 1; n >= 0; n--) begin
         if (px >= m_x[n] && px < m_x[n] + m_w[n] && py >= m_y[n] && py < m_y[n] + m_h[n])
            return m_c[n];
      end
      return BG;
   endfunction

   function automatic logic [15:0] stream_word(input int k);
      int n;
      n = k / 6;
      case (k % 6)
         0:       return 16'hA500 ^ 16'(n);
         1:       return 16'(m_x[n]);
         2:       return 16'(m_y[n]);
         3:       return 16'(m_w[n]);
         4:       return 16'(m_h[n]);
         default: return m_c[n];
      endcase
   endfunction

   task automatic query(input int px, input int py, input logic [15:0] exp, input string name);
      pixel_x     = 16'(px);
      pixel_y     = 16'(py);
      query_valid = 1'b1;
      tick();
      query_valid = 1'b0;
      pixel_x     = 16'($urandom);
      chk({name, "_valid"}, 32'(pixel_valid), 32'd1);
      chk(name, 32'(pixel_color), 32'(exp));
      $display("query (%0h,%0h) color=%0h expected=%0h", px, py, pixel_color, exp);
      tick();
      chk({name, "_hold"}, 32'(pixel_color), 32'(exp));
      chk({name, "_vlow"}, 32'(pixel_valid), 32'd0);
   endtask

   // Entries that cover nothing: one of width/height is zero, the rest random.
   task automatic setup_empty();
      for (int n = 0; n < RC; n++) begin
         m_x[n] = $urandom_range(0, 65535);
         m_y[n] = $urandom_range(0, 65535);
         m_c[n] = 16'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            m_w[n] = 0;
            m_h[n] = $urandom_range(0, 65535);
         end else begin
            m_w[n] = $urandom_range(0, 65535);
            m_h[n] = 0;
         end
      end
   endtask

   task automatic setup_a();
      setup_empty();
      m_x[0] = 10;      m_y[0] = 20; m_w[0] = 5;  m_h[0] = 5; m_c[0] = 16'hF800;
      m_x[5] = 'hFFF0;  m_y[5] = 0;  m_w[5] = 'h20; m_h[5] = 1; m_c[5] = 16'h5A5A;
   endtask

   task automatic setup_b();
      setup_empty();
      m_x[3]  = 0;  m_y[3]  = 0;  m_w[3]  = 100; m_h[3]  = 100; m_c[3]  = 16'h001F;
      m_x[40] = 50; m_y[40] = 50; m_w[40] = 10;  m_h[40] = 10;  m_c[40] = 16'h07E0;
   endtask

   task automatic setup_rand(input bit wide);
      for (int n = 0; n < RC; n++) begin
         m_c[n] = 16'($urandom);
         if (wide) begin
            m_x[n] = $urandom_range(0, 65535);
            m_y[n] = $urandom_range(0, 65535);
            m_w[n] = $urandom_range(0, 65535);
            m_h[n] = $urandom_range(0, 65535);
         end else begin
            m_x[n] = $urandom_range(0, 60);
            m_y[n] = $urandom_range(0, 60);
            m_w[n] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
            m_h[n] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
         end
      end
   endtask

   // Streams the model table; optional copy_start pulse, query, or reset at a given word.
   task automatic do_load(input int pulse_word, input int query_word, input int qx, input int qy,
                          input int reset_word);
      copy_start = 1'b1;
      tick();
      copy_start = 1'b0;
      chk("start_loading", 32'(loading), 32'd1);
      chk("start_ready_low", 32'(frame_ready), 32'd0);
      for (int d = 0; d < SD - 1; d++) begin
         data_in = 16'($urandom);
         tick();
      end
      for (int k = 0; k < 6 * RC; k++) begin
         data_in = stream_word(k);
         if (k == pulse_word) copy_start = 1'b1;
         if (k == query_word) begin
            query_valid = 1'b1;
            pixel_x     = 16'(qx);
            pixel_y     = 16'(qy);
         end
         if (k == reset_word) begin
            reset       = 1'b1;
            query_valid = 1'b1;
            copy_start  = 1'b1;
         end
         tick();
         copy_start  = 1'b0;
         query_valid = 1'b0;
         if (k == reset_word) begin
            chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
            chk("rst_pixel_color", 32'(pixel_color), 32'd0);
            chk("rst_frame_ready", 32'(frame_ready), 32'd0);
            chk("rst_loading", 32'(loading), 32'd0);
            $display("reset at word %0d: valid=%0d color=%0h ready=%0d loading=%0d",
                     k, pixel_valid, pixel_color, frame_ready, loading);
            reset = 1'b0;
            return;
         end
         if (k == query_word) begin
            chk("load_q_valid", 32'(pixel_valid), 32'd1);
            chk("load_q_color", 32'(pixel_color), 32'(BG));
         end
         if (k == 6 * RC - 2) begin
            chk("last_loading", 32'(loading), 32'd1);
            chk("last_ready_low", 32'(frame_ready), 32'd0);
         end
      end
      chk("done_ready", 32'(frame_ready), 32'd1);
      chk("done_loading", 32'(loading), 32'd0);
      $display("load done: ready=%0d loading=%0d", frame_ready, loading);
   endtask

   task automatic apply_vecs(input int frame);
      for (int i = 0; i < 17; i++) begin
         if (vecs[i].frame == frame)
            query(vecs[i].px, vecs[i].py, vecs[i].exp, $sformatf("vec%0d", i));
      end
   endtask

   task automatic rand_queries(input bit wide);
      int n, px, py;
      for (int i = 0; i < 30; i++) begin
         if (wide) begin
            n  = $urandom_range(0, RC - 1);
            px = (m_x[n] + $urandom_range(0, m_w[n])) & 'hFFFF;
            py = (m_y[n] + $urandom_range(0, m_h[n])) & 'hFFFF;
         end else begin
            px = $urandom_range(0, 75);
            py = $urandom_range(0, 75);
         end
         query(px, py, ref_color(px, py), "rand");
      end
   endtask

   initial begin
      vecs[0]  = '{0, 12, 22, 16'hF800};
      vecs[1]  = '{0, 15, 22, BG};
      vecs[2]  = '{0, 14, 24, 16'hF800};
      vecs[3]  = '{0, 10, 20, 16'hF800};
      vecs[4]  = '{0, 9, 22, BG};
      vecs[5]  = '{0, 12, 25, BG};
      vecs[6]  = '{0, 'hFFFF, 0, 16'h5A5A};
      vecs[7]  = '{0, 'h0005, 0, BG};
      vecs[8]  = '{0, 'hFFF0, 0, 16'h5A5A};
      vecs[9]  = '{0, 'hFFEF, 0, BG};
      vecs[10] = '{0, 'hFFFF, 1, BG};
      vecs[11] = '{1, 55, 55, 16'h07E0};
      vecs[12] = '{1, 49, 55, 16'h001F};
      vecs[13] = '{1, 59, 59, 16'h07E0};
      vecs[14] = '{1, 60, 59, 16'h001F};
      vecs[15] = '{1, 100, 0, BG};
      vecs[16] = '{1, 99, 99, 16'h001F};

      reset       = 1'b1;
      copy_start  = 1'b0;
      data_in     = '0;
      query_valid = 1'b0;
      pixel_x     = '0;
      pixel_y     = '0;
      tick();
      tick();
      copy_start  = 1'b1;
      query_valid = 1'b1;
      tick();
      chk("reset_pixel_valid", 32'(pixel_valid), 32'd0);
      chk("reset_pixel_color", 32'(pixel_color), 32'd0);
      chk("reset_frame_ready", 32'(frame_ready), 32'd0);
      chk("reset_loading", 32'(loading), 32'd0);
      $display("reset: valid=%0d color=%0h ready=%0d loading=%0d",
               pixel_valid, pixel_color, frame_ready, loading);
      copy_start  = 1'b0;
      query_valid = 1'b0;
      reset       = 1'b0;
      tick();
      chk("idle_loading", 32'(loading), 32'd0);
      query(12, 22, BG, "idle_q");

      setup_a();
      do_load(100, -1, 0, 0, -1);
      apply_vecs(0);

      setup_b();
      do_load(-1, 0, 12, 22, -1);
      apply_vecs(1);

      for (int r = 0; r < 3; r++) begin
         setup_rand(r == 2);
         do_load(-1, -1, 0, 0, -1);
         rand_queries(r == 2);
      end

      setup_b();
      do_load(-1, -1, 0, 0, -1);
      apply_vecs(1);

      setup_rand(1'b0);
      do_load(-1, -1, 0, 0, 200);
      tick();
      tick();
      chk("post_rst_loading", 32'(loading), 32'd0);
      chk("post_rst_ready", 32'(frame_ready), 32'd0);
      query(55, 55, BG, "post_rst_q");
      chk("post_rst_ready2", 32'(frame_ready), 32'd0);

      setup_a();
      do_load(-1, -1, 0, 0, -1);
      apply_vecs(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
